// File: rtl/lane_permute_pipe_if.sv
// Handshake bundle for lane_permute_pipe.
// Carries the input side (valid/ready, data word, permutation mode, rotate amount)
// and the output side (valid/ready, permuted word).
//   slave  : the pipeline's view (consumes in_*, produces out_*)
//   master : the surrounding logic's view (source and sink)
interface lane_permute_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LANE  = 8
);
  localparam int LANES = WIDTH / LANE;
  localparam int ROT_W = ($clog2(LANES) > 1) ? $clog2(LANES) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [ROT_W-1:0] in_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_mode, in_rot, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, in_rot, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lane_permute_pipe.sv
// Elastic lane-permuting pipeline.
// Splits each accepted word into LANES = WIDTH/LANE lanes, reorders the lanes
// according to in_mode (0 pass, 1 reverse, 2 rotate toward MSB by in_rot,
// 3 swap adjacent lane pairs), then carries the result through DEPTH
// valid/ready register stages. Bits inside a lane are never reordered.
// Ports:
//   CLK           rising-edge clock
//   ASYNCRESET_N  asynchronous active-low reset; empties the pipe and zeroes data
//   bus           lane_permute_pipe_if.slave: in_valid/in_ready/in_data/in_mode/
//                 in_rot on the input side, out_valid/out_ready/out_data on the output
//   occupancy     number of full stages
module lane_permute_pipe #(
  parameter  int WIDTH = 16,
  parameter  int LANE  = 8,
  parameter  int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                CLK,
  input  logic                ASYNCRESET_N,
  lane_permute_pipe_if.slave  bus,
  output logic [OCC_W-1:0]    occupancy
);

  localparam int LANES = WIDTH / LANE;

  // Source lane for output lane j; rot is already reduced modulo LANES.
  function automatic int src_lane(input int j, input logic [1:0] mode, input int rot);
    case (mode)
      2'd0:    return j;
      2'd1:    return LANES - 1 - j;
      2'd2:    return (j - rot + LANES) % LANES;
      // With an odd lane count the top lane has no partner and passes through.
      default: return ((j ^ 1) < LANES) ? (j ^ 1) : j;
    endcase
  endfunction

  logic [WIDTH-1:0] perm_data;
  int               rot_lanes;

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    perm_data = '0;
    rot_lanes = int'(bus.in_rot) % LANES;
    for (int j = 0; j < LANES; j++) begin
      perm_data[j*LANE +: LANE] = bus.in_data[src_lane(j, bus.in_mode, rot_lanes)*LANE +: LANE];
    end
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] full_q;

  // A stage may advance when it or any stage downstream of it has room, or the
  // sink is taking a word. Built as a running OR from the output end so the
  // ready path stays purely combinational from out_ready.
  logic [DEPTH-1:0] adv;

  always_comb begin
    logic room;
    adv  = '0;
    room = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~full_q[i];
      adv[i] = room;
    end
  end

  // What each stage would load: the permuter for stage 0, the previous stage otherwise.
  logic [WIDTH-1:0] up_data  [DEPTH];
  logic [DEPTH-1:0] up_valid;

  always_comb begin
    up_valid    = '0;
    up_valid[0] = bus.in_valid;
    up_data[0]  = perm_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_valid[i] = full_q[i-1];
      up_data[i]  = data_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its upstream neighbour.
  always_ff @(posedge CLK or negedge ASYNCRESET_N) begin
    if (!ASYNCRESET_N) begin
      full_q <= '0;
      // NOTE: the data registers are reset too, so out_data reads 0 rather than X
      // after reset; this is a handful of flops, not a RAM.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          full_q[i] <= up_valid[i];
          // Data only moves with a real word, so an emptied stage keeps its last value.
          if (up_valid[i]) begin
            data_q[i] <= up_data[i];
          end
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(full_q[i]);
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = full_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_lane_permute_pipe.sv
// Self-checking bench for lane_permute_pipe.
// Three instances share clock and reset: 16/8/2 (main), 32/8/2 (rotate and
// pair-swap on four lanes) and 16/8/1 (single-stage streaming). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge. Each
// instance has an expected-value queue: the expected word is pushed when an
// input transfer is seen and popped when an output transfer is seen.
module tb_lane_permute_pipe;

  logic clk;
  logic rst_n;

  lane_permute_pipe_if #(.WIDTH(16), .LANE(8)) b16 ();
  lane_permute_pipe_if #(.WIDTH(32), .LANE(8)) b32 ();
  lane_permute_pipe_if #(.WIDTH(16), .LANE(8)) b1 ();

  logic [1:0] occ16;
  logic [1:0] occ32;
  logic [0:0] occ1;

  lane_permute_pipe #(.WIDTH(16), .LANE(8), .DEPTH(2)) dut16 (
    .CLK(clk), .ASYNCRESET_N(rst_n), .bus(b16), .occupancy(occ16));
  lane_permute_pipe #(.WIDTH(32), .LANE(8), .DEPTH(2)) dut32 (
    .CLK(clk), .ASYNCRESET_N(rst_n), .bus(b32), .occupancy(occ32));
  lane_permute_pipe #(.WIDTH(16), .LANE(8), .DEPTH(1)) dut1 (
    .CLK(clk), .ASYNCRESET_N(rst_n), .bus(b1), .occupancy(occ1));

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] q16 [$];
  logic [31:0] q32 [$];
  logic [31:0] q1  [$];
  logic [31:0] e16, e32, e1;   // expected result of the word currently presented
  int          out_cnt16 = 0;
  logic        rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
    end
  endtask

  // Reference permutation written from the destination side, byte lanes only.
  function automatic logic [31:0] model(input logic [31:0] d, input int n,
                                        input int mode, input int rot);
    logic [7:0]  l [4];
    logic [7:0]  o [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      l[k] = d[k*8 +: 8];
      o[k] = l[k];
    end
    case (mode)
      1: for (int j = 0; j < n; j++) o[j] = l[n-1-j];
      2: for (int k = 0; k < n; k++) o[(k + rot) % n] = l[k];
      3: for (int k = 0; k + 1 < n; k += 2) begin
           o[k]   = l[k+1];
           o[k+1] = l[k];
         end
      default: ;
    endcase
    r = '0;
    for (int k = 0; k < n; k++) r[k*8 +: 8] = o[k];
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  // Scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b16.in_valid && b16.in_ready) q16.push_back(e16);
      if (b16.out_valid && b16.out_ready) begin
        out_cnt16++;
        if (q16.size() == 0) check("d16_spurious_out", 32'(q16.size()), 32'd1);
        else                 check("d16_out", 32'(b16.out_data), q16.pop_front());
      end
      if (b32.in_valid && b32.in_ready) q32.push_back(e32);
      if (b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) check("d32_spurious_out", 32'(q32.size()), 32'd1);
        else                 check("d32_out", b32.out_data, q32.pop_front());
      end
      if (b1.in_valid && b1.in_ready) q1.push_back(e1);
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) check("d1_spurious_out", 32'(q1.size()), 32'd1);
        else                check("d1_out", 32'(b1.out_data), q1.pop_front());
      end
    end
  end

  // Random sink backpressure for the stream test.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) b16.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [15:0] d, input logic [1:0] m, input logic r,
                        input logic [31:0] exp);
    logic acc = 1'b0;
    b16.in_data  = d;
    b16.in_mode  = m;
    b16.in_rot   = r;
    b16.in_valid = 1'b1;
    e16          = exp;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = b16.in_ready;
      tick();
    end
    b16.in_valid = 1'b0;
    check("send16_accept", 32'(acc), 32'd1);
  endtask

  task automatic send32(input logic [31:0] d, input logic [1:0] m, input logic [1:0] r,
                        input logic [31:0] exp);
    logic acc = 1'b0;
    b32.in_data  = d;
    b32.in_mode  = m;
    b32.in_rot   = r;
    b32.in_valid = 1'b1;
    e32          = exp;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = b32.in_ready;
      tick();
    end
    b32.in_valid = 1'b0;
    check("send32_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (q16.size() == 0 && q32.size() == 0 && q1.size() == 0) break;
    end
    check(tag, 32'(q16.size() + q32.size() + q1.size()), 32'd0);
    tick();
  endtask

  initial begin
    int          lat;
    logic        got;
    logic        acc;
    logic [15:0] d;
    logic [1:0]  m;
    logic        r;
    int          rot_req;

    rst_n = 1'b0;
    e16 = '0; e32 = '0; e1 = '0;
    b16.in_valid = 1'b0; b16.in_data = '0; b16.in_mode = '0; b16.in_rot = '0; b16.out_ready = 1'b0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_mode = '0; b32.in_rot = '0; b32.out_ready = 1'b0;
    b1.in_valid  = 1'b0; b1.in_data  = '0; b1.in_mode  = '0; b1.in_rot  = '0; b1.out_ready  = 1'b0;

    // Reset state, sampled while reset is held.
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready",  32'(b16.in_ready),  32'd1);
    check("rst_out_valid", 32'(b16.out_valid), 32'd0);
    check("rst_out_data",  32'(b16.out_data),  32'd0);
    check("rst_occupancy", 32'(occ16),         32'd0);
    #1 rst_n = 1'b1;

    // 1: reverse on 16 bits, latency DEPTH.
    tick();
    b16.out_ready = 1'b1;
    b16.in_data   = 16'hA1B2;
    b16.in_mode   = 2'd1;
    b16.in_rot    = 1'b0;
    b16.in_valid  = 1'b1;
    e16           = 32'h0000B2A1;
    @(negedge clk);
    check("t1_in_ready", 32'(b16.in_ready), 32'd1);
    tick();
    b16.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (b16.out_valid) begin
        lat = c;
        got = 1'b1;
      end
    end
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_data", 32'(b16.out_data), 32'h0000B2A1);
    drain("t1_drain");

    // 2: four lanes: rotate, wrapped rotate, pair swap, pass.
    b32.out_ready = 1'b1;
    rot_req = 5;
    send32(32'h44332211, 2'd2, 2'd1,         32'h33221144);
    send32(32'h44332211, 2'd2, rot_req[1:0], 32'h33221144);
    send32(32'h44332211, 2'd3, 2'd0,         32'h33441122);
    send32(32'h44332211, 2'd0, 2'd3,         32'h44332211);
    send32(32'h44332211, 2'd2, 2'd0,         32'h44332211);
    drain("t2_drain");

    // 3: backpressure fills the pipe; third word waits, head word stays stable.
    b16.out_ready = 1'b0;
    send16(16'h0001, 2'd1, 1'b0, 32'h00000100);
    send16(16'h0002, 2'd1, 1'b0, 32'h00000200);
    b16.in_data  = 16'h0003;
    b16.in_mode  = 2'd1;
    b16.in_valid = 1'b1;
    e16          = 32'h00000300;
    repeat (3) @(negedge clk);
    check("t3_occupancy", 32'(occ16),         32'd2);
    check("t3_in_ready",  32'(b16.in_ready),  32'd0);
    check("t3_out_valid", 32'(b16.out_valid), 32'd1);
    check("t3_head",      32'(b16.out_data),  32'h00000100);
    tick();
    b16.in_rot = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_stable", 32'(b16.out_data), 32'h00000100);
    tick();
    b16.out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = b16.in_ready;
      tick();
    end
    b16.in_valid = 1'b0;
    check("t3_third_accept", 32'(acc), 32'd1);
    drain("t3_drain");

    // 4: 100-word stream with random sink backpressure.
    out_cnt16 = 0;
    rand_rdy  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      r = 1'($urandom_range(0, 1));
      send16(d, m, r, model(32'(d), 2, int'(m), int'(r)));
    end
    rand_rdy      = 1'b0;
    @(posedge clk);
    #2 b16.out_ready = 1'b1;
    drain("t4_drain");
    check("t4_count", 32'(out_cnt16), 32'd100);

    // 6: single stage, accept and emit every cycle.
    b1.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b1.in_data  = 16'h1000 + 16'(i * 16'h0111);
      b1.in_mode  = 2'd1;
      b1.in_valid = 1'b1;
      e1          = {16'h0000, b1.in_data[7:0], b1.in_data[15:8]};
      @(negedge clk);
      if (i > 0) begin
        check("t6_occupancy", 32'(occ1),        32'd1);
        check("t6_in_ready",  32'(b1.in_ready), 32'd1);
      end
      tick();
    end
    b1.in_valid = 1'b0;
    drain("t6_drain");

    // 5: asynchronous reset between edges discards stalled words.
    b16.out_ready = 1'b0;
    send16(16'h5A01, 2'd0, 1'b0, 32'h00005A01);
    send16(16'h5A02, 2'd0, 1'b0, 32'h00005A02);
    check("t5_full", 32'(occ16), 32'd2);
    #3 rst_n = 1'b0;
    q16.delete();
    #1;
    check("t5_out_valid", 32'(b16.out_valid), 32'd0);
    check("t5_occupancy", 32'(occ16),         32'd0);
    check("t5_out_data",  32'(b16.out_data),  32'd0);
    check("t5_in_ready",  32'(b16.in_ready),  32'd1);
    #12 rst_n = 1'b1;
    tick();
    b16.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_replay", 32'(b16.out_valid), 32'd0);
    check("t5_empty",     32'(occ16),         32'd0);

    check("final_queues", 32'(q16.size() + q32.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
